// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and sizing helper for the multiply/divide unit
package muldiv_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIXUP,
      DONE
   } md_state_e;

   // Iteration counter width; never below one bit.
   function automatic int md_cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of shift-add multiply or restoring divide
//   i_div  : 1 selects the divide iteration, 0 the multiply iteration
//   i_acc  : 2*WIDTH accumulator {hi, lo}
//            multiply: hi = partial product, lo = remaining multiplier bits
//            divide  : hi = partial remainder, lo = dividend bits / quotient bits
//   i_d    : multiplicand or divisor magnitude
//   o_acc  : accumulator after this iteration
module muldiv_step #(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic               i_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_d,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH-1:0]   w_hi, w_lo, w_sub;
   logic [WIDTH:0]     w_sum, w_sh;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_mul, w_dv;

   assign w_hi = i_acc[2*WIDTH-1:WIDTH];
   assign w_lo = i_acc[WIDTH-1:0];

   // Multiply: add the multiplicand when the current multiplier bit is set, then
   // shift the whole accumulator right, carry included.
   assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_d} : '0);
   assign w_mul = {w_sum, w_lo[WIDTH-1:1]};

   // Divide: bring the next dividend bit into the remainder and trial-subtract.
   // The difference is kept only to WIDTH bits; when the trial succeeds it is
   // below the divisor, so the dropped top bit is always zero.
   assign w_sh  = {w_hi, w_lo[WIDTH-1]};
   assign w_ge  = w_sh >= {1'b0, i_d};
   assign w_sub = w_sh[WIDTH-1:0] - i_d;
   assign w_dv  = {w_ge ? w_sub : w_sh[WIDTH-1:0], w_lo[WIDTH-2:0], w_ge};

   assign o_acc = i_div ? w_dv : (MUL_EN ? w_mul : '0);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with annul and stall request
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request, taken in IDLE or DONE when not annulled
//   i_op           : MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   i_a, i_b       : multiplicand/dividend, multiplier/divisor
//   i_annul        : flush any in-flight operation
//   o_busy         : high in PREP, CALC, FIXUP
//   o_stall_req    : busy, or a request about to be accepted from IDLE
//   o_valid        : one-cycle result pulse in DONE
//   o_hi, o_lo     : upper product / remainder, lower product / quotient
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_annul,
   output logic             o_busy,
   output logic             o_stall_req,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int CNT_W = md_cnt_w(WIDTH);

   md_state_e          r_state, w_next;
   md_op_e             r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_d, r_hi, r_lo;
   logic [2*WIDTH-1:0] r_acc, w_step, w_prod;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_neg_res, r_neg_rem;
   logic               w_accept, w_sgn, w_div, w_neg_a, w_neg_b;
   logic [WIDTH-1:0]   w_q, w_r;

   assign w_accept = i_start & ~i_annul & ((r_state == IDLE) | (r_state == DONE));
   assign w_sgn    = (r_op == MD_MULT) | (r_op == MD_DIV);
   assign w_div    = (r_op == MD_DIV) | (r_op == MD_DIVU);
   assign w_neg_a  = w_sgn & r_a[WIDTH-1];
   assign w_neg_b  = w_sgn & r_b[WIDTH-1];
   assign w_prod   = MUL_EN ? (r_neg_res ? -r_acc : r_acc) : '0;
   assign w_q      = r_acc[WIDTH-1:0];
   assign w_r      = r_acc[2*WIDTH-1:WIDTH];

   muldiv_step #(.WIDTH(WIDTH), .MUL_EN(MUL_EN)) u_step (
      .i_div (w_div),
      .i_acc (r_acc),
      .i_d   (r_d),
      .o_acc (w_step)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_busy      = (r_state == PREP) | (r_state == CALC) | (r_state == FIXUP);
      o_valid     = r_state == DONE;
      o_stall_req = o_busy | (i_start & ~i_annul & (r_state == IDLE));
      case (r_state)
         IDLE:    w_next = w_accept ? PREP : IDLE;
         PREP:    w_next = CALC;
         CALC:    w_next = (r_cnt == CNT_W'(WIDTH-1)) ? FIXUP : CALC;
         FIXUP:   w_next = DONE;
         DONE:    w_next = w_accept ? PREP : IDLE;
         default: w_next = IDLE;
      endcase
      if (i_annul) w_next = IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op      <= MD_MULT;
         r_a       <= '0;
         r_b       <= '0;
         r_d       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         if (w_accept) begin
            r_op <= md_op_e'(i_op);
            r_a  <= i_a;
            r_b  <= i_b;
         end
         // Work on magnitudes; a negated most-negative value is still the
         // correct unsigned magnitude.
         if (r_state == PREP) begin
            r_acc     <= {{WIDTH{1'b0}}, w_neg_a ? -r_a : r_a};
            r_d       <= w_neg_b ? -r_b : r_b;
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
            r_cnt     <= '0;
         end
         if (r_state == CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 1'b1;
         end
         // An annul landing on FIXUP must leave the committed hi/lo untouched.
         if (r_state == FIXUP && !i_annul) begin
            if (!w_div) begin
               r_hi <= w_prod[2*WIDTH-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end else if (r_b == '0) begin
               r_hi <= r_a;
               r_lo <= '1;
            end else begin
               r_hi <= r_neg_rem ? -w_r : w_r;
               r_lo <= r_neg_res ? -w_q : w_q;
            end
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector self-checking bench for muldiv_unit
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         annul = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, stall_req, valid;
   logic [W-1:0] hi, lo;
   int           n_vec = 0;
   int           n_bad = 0;
   int           lat, bcnt, pulses;

   muldiv_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_op        (op),
      .i_a         (a),
      .i_b         (b),
      .i_annul     (annul),
      .o_busy      (busy),
      .o_stall_req (stall_req),
      .o_valid     (valid),
      .o_hi        (hi),
      .o_lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Cycles from the accept edge to the first sample showing valid; busy is
   // counted on the samples in between.
   task automatic wait_done(output int n, output int bc);
      n = 0;
      bc = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (valid) break;
         bc += int'(busy);
      end
   endtask

   task automatic op_chk(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
      issue(o, x, y);
      wait_done(lat, bcnt);
      chk({tag, "_lat"}, lat, 34);
      chk({tag, "_hi"}, hi, e_hi);
      chk({tag, "_lo"}, lo, e_lo);
   endtask

   initial begin
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_stall", stall_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      issue(MD_DIVU, 100, 7);
      wait_done(lat, bcnt);
      chk("divu_lat", lat, 34);
      chk("divu_busy_cycles", bcnt, 33);
      chk("divu_busy_done", busy, 0);
      chk("divu_lo", lo, 14);
      chk("divu_hi", hi, 2);
      @(posedge clk);
      #1;
      chk("divu_valid_pulse", valid, 0);

      op_chk("div_neg_a", MD_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      op_chk("div_neg_b", MD_DIV, 7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD);

      op_chk("mult", MD_MULT, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      op_chk("multu", MD_MULTU, 32'hFFFF_FFFF, 2, 1, 32'hFFFF_FFFE);
      issue(MD_MULT, 32'hFFFF_FFFF, 2);
      chk("b2b_busy", busy, 1);
      wait_done(lat, bcnt);
      chk("b2b_lat", lat, 34);
      chk("b2b_hi", hi, 32'hFFFF_FFFF);
      chk("b2b_lo", lo, 32'hFFFF_FFFE);

      op_chk("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
      op_chk("divu_by0", MD_DIVU, 5, 0, 5, 32'hFFFF_FFFF);
      op_chk("div_by0", MD_DIV, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

      op_chk("pre_annul", MD_DIVU, 100, 7, 2, 14);
      issue(MD_DIVU, 100, 7);
      repeat (11) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk);
      #1;
      annul = 1'b0;
      chk("annul_busy", busy, 0);
      chk("annul_stall", stall_req, 0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         pulses += int'(valid);
      end
      chk("annul_no_valid", pulses, 0);
      chk("annul_hi", hi, 2);
      chk("annul_lo", lo, 14);

      start = 1'b1;
      annul = 1'b1;
      op = MD_DIVU;
      a = 9;
      b = 2;
      #1;
      chk("annul_start_stall", stall_req, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      annul = 1'b0;
      chk("annul_start_busy", busy, 0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         pulses += int'(valid);
      end
      chk("annul_start_no_valid", pulses, 0);
      chk("annul_start_lo", lo, 14);

      issue(MD_DIVU, 100, 7);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", valid, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      @(posedge clk);
      #1;
      chk("arst_hold_busy", busy, 0);
      rst_n = 1'b1;
      op_chk("post_rst_multu", MD_MULTU, 3, 5, 0, 15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the execute stage. It replaces the divide-only engine with a combined unit covering MULT/MULTU/DIV/DIVU at configurable width. It adds an annul input for exception flush and a stall-request output that the hazard unit consumes. Results go to the HI/LO path registers: hi holds the upper product or the remainder, lo holds the lower product or the quotient.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each, the product is 2*WIDTH bits.
MUL_EN, 1, when 0 the multiply ops are not built and a multiply start completes with hi=lo=0 through the normal latency.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request; sampled in IDLE or DONE.
op  input  2  2'b00 MULT (signed), 2'b01 MULTU, 2'b10 DIV (signed), 2'b11 DIVU.
a  input  WIDTH  multiplicand or dividend.
b  input  WIDTH  multiplier or divisor.
annul  input  1  cancels any in-flight operation (exception flush).
busy  output  1  high in PREP, CALC and FIXUP.
stall_req  output  1  combinational: busy | (start & ~annul & state==IDLE).
valid  output  1  one-cycle result pulse.
hi  output  WIDTH  remainder or upper product.
lo  output  WIDTH  quotient or lower product.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, busy=0, valid=0, hi=0, lo=0, counter=0. Applies in any state, including mid-CALC.
- FSM states: IDLE, PREP, CALC, FIXUP, DONE.
- IDLE -> PREP on start & ~annul. At that edge a, b and op are latched.
- DONE -> PREP on start & ~annul, giving back-to-back issue. Otherwise DONE -> IDLE.
- Start while busy is ignored; latched operands are unaffected.
- PREP (1 cycle): form operand magnitudes (absolute value for signed ops). Record the result-sign and remainder-sign flags. Clear the accumulator and counter. Then go to CALC.
- CALC (exactly WIDTH cycles): one bit per cycle; the counter runs 0..WIDTH-1 and the state moves to FIXUP when counter==WIDTH-1.
  - Multiply: shift-add on the 2*WIDTH accumulator.
  - Divide: restoring; shift the partial remainder, trial-subtract the divisor, set the quotient bit if the result is non-negative.
- FIXUP (1 cycle): apply signs.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - hi and lo are registered here and become visible in DONE.
- DONE (1 cycle): valid=1.
- Latency: valid is high exactly WIDTH+2 cycles after the accept edge (34 for WIDTH=32).
- hi and lo hold their value until the next FIXUP or reset.
- Divide by zero, all variants: lo={WIDTH{1'b1}}, hi=a (original dividend, unmodified). Sign fixup is bypassed; normal latency applies.
- Signed overflow (most-negative / -1): lo=most-negative, hi=0, which the algorithm produces naturally. No trap is raised.
- annul=1 in any state: next state is IDLE. busy drops after that edge, valid is not asserted, and hi/lo keep their previous values.
- annul & start in the same cycle: annul wins and nothing is accepted.
- annul in DONE: valid is still high that cycle, since the result is already committed; the pipeline qualifies it with its own flush.
- Counter width is clog2(WIDTH) bits. There is no wrap, because the state exits at WIDTH-1.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - state enum: IDLE, PREP, CALC, FIXUP, DONE.
  - a clog2-based counter-width localparam function.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide), parametrised by WIDTH.
- The FSM, counter and sign fixup stay in muldiv_unit.

Test Plan:
1. DIVU a=100, b=7 -> lo=14, hi=2; valid exactly 34 cycles after accept; busy high for 33 of those cycles.
2. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
3. MULT a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=1, lo=0xFFFFFFFE. Start asserted in DONE -> next op accepted with no IDLE cycle.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV a=-5, b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFB.
5. Issue DIVU 100/7 with prior hi/lo=2/14, then annul at CALC cycle 10 -> IDLE next edge, no valid pulse, hi/lo stay 2/14. annul and start together in IDLE -> stall_req=0 and no accept.
6. Assert rst low mid-CALC between clock edges -> busy, valid, hi and lo are 0 immediately without a clock edge. After release, a fresh MULTU 3*5 -> lo=15, hi=0.
